// File: rtl/ff_bank_sched_pkg.sv
// Shared encodings for the ff_bank_sched scheduler: op codes and FSM states.
package ff_bank_sched_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_LOAD = 2'b00;
  localparam logic [OP_W-1:0] OP_SET  = 2'b01;
  localparam logic [OP_W-1:0] OP_CLR  = 2'b10;
  localparam logic [OP_W-1:0] OP_INV  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first req at or after ptr wins, wrapping at N.
module rr_arb
  import ff_bank_sched_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'((32'(ptr) + i) % N);
      if (!any_gnt && req[idx]) begin
        any_gnt  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/ff_bank_sched.sv
// Round-robin scheduler sharing one W-bit register between N requesters.
// Optional op counter output op_cnt is built when FF_BANK_SCHED_STATS_EN is defined.
module ff_bank_sched
  import ff_bank_sched_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 2
) (
  input  logic            C,
  input  logic            R,
  input  logic [N-1:0]    req,
  input  logic [OP_W*N-1:0] op,
  input  logic [N*W-1:0]  data,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    done,
  output logic [W-1:0]    Q,
  output logic            busy
`ifdef FF_BANK_SCHED_STATS_EN
  ,
  output logic [15:0]     op_cnt
`endif
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(LAT + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [W-1:0]    data_q, data_d;
  logic [W-1:0]    q_q, q_d;
  logic [N-1:0]    done_q, done_d;

  logic [N-1:0]    arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  rr_arb #(
    .N  (N),
    .IW (IW)
  ) u_rr_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_gnt (arb_any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    data_d  = data_q;
    q_d     = q_q;
    done_d  = '0;
    ack     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          if (!R) ack = arb_gnt;
          gnt_d = arb_idx;
          // One-hot mux keeps every slice select constant.
          for (int unsigned i = 0; i < N; i++) begin
            if (arb_gnt[i]) begin
              op_d   = op[OP_W*i +: OP_W];
              data_d = data[W*i +: W];
            end
          end
          cnt_d   = CW'(LAT - 1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          unique case (op_q)
            OP_LOAD: q_d = data_q;
            OP_SET:  q_d = '1;
            OP_CLR:  q_d = '0;
            OP_INV:  q_d = ~q_q;
          endcase
          done_d[gnt_q] = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        ptr_d   = (gnt_q == IW'(N - 1)) ? '0 : gnt_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
      q_q     <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      data_q  <= data_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
  assign Q    = q_q;
  assign busy = (state_q != ST_IDLE);

`ifdef FF_BANK_SCHED_STATS_EN
  logic [15:0] op_cnt_q;

  always_ff @(posedge C) begin
    if (R) begin
      op_cnt_q <= '0;
    end else if (state_q == ST_RESP && op_cnt_q != 16'hFFFF) begin
      op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  assign op_cnt = op_cnt_q;
`endif

endmodule

// File: tb/tb_ff_bank_sched.sv
// Scoreboard bench for ff_bank_sched (N=4, W=8, LAT=2): expected ack/done events are queued
// by the stimulus and popped by a negedge monitor.
module tb_ff_bank_sched;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned LAT = 2;

  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] SET  = 2'b01;
  localparam logic [1:0] CLR  = 2'b10;
  localparam logic [1:0] INV  = 2'b11;

  logic           C = 1'b0;
  logic           R;
  logic [N-1:0]   req;
  logic [2*N-1:0] op;
  logic [N*W-1:0] data;
  logic [N-1:0]   ack;
  logic [N-1:0]   done;
  logic [W-1:0]   Q;
  logic           busy;
`ifdef FF_BANK_SCHED_STATS_EN
  logic [15:0]    op_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [3:0] v;
    logic [7:0] q;
    int         cyc;
  } exp_t;

  exp_t exp_ack[$];
  exp_t exp_done[$];

  ff_bank_sched #(
    .N   (N),
    .W   (W),
    .LAT (LAT)
  ) dut (
    .C    (C),
    .R    (R),
    .req  (req),
    .op   (op),
    .data (data),
    .ack  (ack),
    .done (done),
    .Q    (Q),
    .busy (busy)
`ifdef FF_BANK_SCHED_STATS_EN
    ,
    .op_cnt (op_cnt)
`endif
  );

  always #5 C = ~C;
  always @(posedge C) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge C);
      #1;
    end
  endtask

  // Move to mid-cycle so combinational outputs have settled.
  task automatic mid();
    #2;
  endtask

  task automatic push_ack(input logic [3:0] v, input int c);
    exp_t e;
    e.v = v; e.q = '0; e.cyc = c;
    exp_ack.push_back(e);
  endtask

  task automatic push_done(input logic [3:0] v, input logic [7:0] q, input int c);
    exp_t e;
    e.v = v; e.q = q; e.cyc = c;
    exp_done.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [7:0] d);
    req[i]         = 1'b1;
    op[2*i +: 2]   = o;
    data[8*i +: 8] = d;
  endtask

  // Lone request from IDLE: ack now, done and new Q three cycles later.
  task automatic issue(input int i, input logic [1:0] o, input logic [7:0] d,
                       input logic [7:0] exp_q);
    set_req(i, o, d);
    push_ack(4'b0001 << i, cyc);
    push_done(4'b0001 << i, exp_q, cyc + 3);
    step();
    req[i] = 1'b0;
    mid(); check("busy_exec1", 32'(busy), 1);
    step(); mid(); check("busy_exec2", 32'(busy), 1);
    step(); mid(); check("busy_resp", 32'(busy), 1);
    step(); mid(); check("busy_after", 32'(busy), 0);
    check("q_after_op", 32'(Q), 32'(exp_q));
  endtask

  always @(negedge C) begin
    exp_t e;
    if (ack != '0) begin
      if (exp_ack.size() == 0) begin
        check("unexpected_ack", 32'(ack), 0);
      end else begin
        e = exp_ack.pop_front();
        check("ack_vec", 32'(ack), 32'(e.v));
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (done != '0) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", 32'(done), 0);
      end else begin
        e = exp_done.pop_front();
        check("done_vec", 32'(done), 32'(e.v));
        check("done_q", 32'(Q), 32'(e.q));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset with a request pending: ack must stay low while R is high.
    R = 1'b1; req = 4'b0001; op = '0; data = '0;
    step(3);
    req = '0;
    step();
    R = 1'b0;
    mid();
    check("rst_q", 32'(Q), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ack", 32'(ack), 0);
`ifdef FF_BANK_SCHED_STATS_EN
    check("rst_op_cnt", 32'(op_cnt), 0);
`endif

    // Single LOAD from requester 2.
    step();
    issue(2, LOAD, 8'hA5, 8'hA5);

    // Round robin with all four requesting.
    R = 1'b1;
    step();
    R = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, LOAD, 8'(i));
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      push_ack(4'b0001 << i, t + 4 * i);
      push_done(4'b0001 << i, 8'(i), t + 4 * i + 3);
    end
    push_ack(4'b0001, t + 16);
    push_done(4'b0001, 8'h00, t + 19);
    step(17);
    req = '0;
    step(3);
    mid();
    check("rr_busy_end", 32'(busy), 0);
`ifdef FF_BANK_SCHED_STATS_EN
    check("op_cnt_five", 32'(op_cnt), 5);
`endif

    // SET, INV, CLR chain on requester 1.
    step();
    issue(1, SET, 8'h00, 8'hFF);
    step();
    issue(1, INV, 8'h00, 8'h00);
    step();
    issue(1, CLR, 8'h00, 8'h00);

    // Late arrival of req[3] and a one-cycle blip on req[0] while busy.
    step();
    t = cyc;
    set_req(2, LOAD, 8'h5A);
    push_ack(4'b0100, t);
    push_done(4'b0100, 8'h5A, t + 3);
    push_ack(4'b1000, t + 4);
    push_done(4'b1000, 8'h77, t + 7);
    step();
    req[2] = 1'b0;
    set_req(3, LOAD, 8'h77);
    step();
    set_req(0, LOAD, 8'h11);
    step();
    req[0] = 1'b0;
    mid();
    check("late_q_first", 32'(Q), 32'h5A);
    step(2);
    req[3] = 1'b0;
    step(3);
    mid();
    check("late_q_second", 32'(Q), 32'h77);

    // Move ptr to 2, then abort a LOAD 3C with R in its second EXEC cycle.
    step();
    issue(1, LOAD, 8'h42, 8'h42);
    step();
    t = cyc;
    set_req(2, LOAD, 8'h3C);
    push_ack(4'b0100, t);
    step();
    req[2] = 1'b0;
    step();
    R = 1'b1;
    step();
    R = 1'b0;
    mid();
    check("abort_q", 32'(Q), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
`ifdef FF_BANK_SCHED_STATS_EN
    check("abort_op_cnt", 32'(op_cnt), 0);
`endif
    step();
    t = cyc;
    for (int i = 0; i < 4; i++) set_req(i, LOAD, 8'h99);
    push_ack(4'b0001, t);
    push_done(4'b0001, 8'h99, t + 3);
    step();
    req = '0;
    step(3);
    mid();
    check("post_abort_q", 32'(Q), 32'h99);

    step(6);
    check("ack_queue_drained", 32'(exp_ack.size()), 0);
    check("done_queue_drained", 32'(exp_done.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ff_bank_sched.md
Name: ff_bank_sched

Overview:
- Scheduler that shares one W-bit state register (a bank of DFFSR-style flops) between N requesters.
- Each requester issues one of four ops: LOAD, SET, CLR or INV.
- Ops are granted round-robin and executed over a fixed multi-cycle latency, modelling a slow shared resource.
- Completion is reported back to the granted requester with a one-cycle done pulse.
- Sits between control agents and the shared register in mapped-netlist test designs.

Parameters:
- N, default 4: number of requesters (N >= 1).
- W, default 8: register width in bits.
- LAT, default 2: execute cycles per op (LAT >= 1).

Ports:
- C  input  1  clock; all state updates on posedge C.
- R  input  1  reset; synchronous, active-high.
- req  input  N  per-requester request; held high until acked.
- op  input  2*N  per-requester op code, slice i = op[2i+1:2i]; stable while req[i] is high.
- data  input  N*W  per-requester load data, slice i = data[W*i+W-1:W*i]; stable while req[i] is high.
- ack  output  N  one-hot accept pulse; op and data are sampled on this edge.
- done  output  N  one-hot completion pulse to the granted requester.
- Q  output  W  shared register contents.
- busy  output  1  high while an op is in flight (EXEC or RESP).

Behaviour:
- Reset (R=1 at posedge C) sets:
  - Q=0, done=0, busy=0, state=IDLE, rr pointer ptr=0, latched op/data/grant cleared.
  - ack forced to 0 while R=1.
  - Reset mid-op aborts it: Q=0, no done pulse is issued.
- States and transitions:
  - IDLE -> EXEC when any req is high.
  - EXEC -> RESP after LAT cycles.
  - RESP -> IDLE unconditionally.
- IDLE:
  - Grant g is the first index with req high, searching ptr, ptr+1, ..., N-1, 0, ... (wrap-around).
  - ack[g]=1 combinationally in that cycle; all other ack bits are 0.
  - At that edge: op/data of g are latched, cnt is loaded with LAT-1, state -> EXEC.
  - With no req high: stay in IDLE, ack=0.
- EXEC:
  - cnt decrements each cycle.
  - On the cycle cnt==0, Q is updated at the edge:
    - LOAD (2'b00): Q<=data_g.
    - SET (2'b01): Q<=all ones.
    - CLR (2'b10): Q<=0.
    - INV (2'b11): Q<=~Q.
  - state -> RESP.
- RESP:
  - done[g]=1 (registered, exactly one cycle).
  - ptr <= (g+1) mod N; state -> IDLE.
- Timing, with ack at cycle t:
  - busy is high in cycles t+1 .. t+LAT+1.
  - New Q is visible in cycle t+LAT+1, the same cycle as done.
  - Next possible ack is at cycle t+LAT+2, so throughput is one op per LAT+2 cycles.
- ack is never asserted outside IDLE.
- Requests arriving during EXEC/RESP wait; req is level-sensitive and has no queue.
- req dropped before ack: no effect. req dropped after ack: the op still completes and done still pulses.
- A requester that re-requests immediately gets lowest priority on the next arbitration (ptr has moved past it).
- N=1: ptr stays 0; behaviour is otherwise identical.

Optional Feature:
- Macro: FF_BANK_SCHED_STATS_EN.
- Defined:
  - Adds output op_cnt [15:0], incremented in each RESP cycle, saturating at 16'hFFFF.
  - Cleared to 0 by R.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package ff_bank_sched_pkg holds:
  - Op encodings OP_LOAD=2'b00, OP_SET=2'b01, OP_CLR=2'b10, OP_INV=2'b11.
  - State encodings ST_IDLE, ST_EXEC, ST_RESP.
  - Op-code width constant OP_W=2.
- Sub-module rr_arb: purely combinational.
  - Inputs: req[N], ptr.
  - Outputs: one-hot gnt[N], gnt_idx[$clog2(N)] and any_gnt.
  - The top level owns ptr and all registers.

Test Plan:
- Reset then single op (N=4, W=8, LAT=2): req[2]=1, op=LOAD, data=8'hA5 at cycle 0.
  - ack[2] in cycle 0.
  - busy in cycles 1-3.
  - Q=8'hA5 and done[2] in cycle 3.
  - ack=0 throughout cycles 1-3.
- Round-robin fairness: req=4'b1111 held, all ops LOAD with data=index.
  - Grants occur in order 0,1,2,3,0, spaced 4 cycles apart.
  - Q sequence is 0,1,2,3.
- SET / INV / CLR chain on requester 1 from Q=0.
  - Q becomes 8'hFF, then 8'h00, then 8'h00 (CLR).
  - Each op produces exactly one done[1] pulse.
- Late arrival and withdrawal:
  - req[3] rises during EXEC: it is acked only in the next IDLE cycle.
  - req[0] pulses for one cycle while busy: it is never acked, and Q is unchanged by it.
- Reset mid-op: assert R in cycle 2 of an EXEC with LOAD 8'h3C.
  - Q=0, busy=0 and no done pulse.
  - The next arbitration starts at requester 0.
- With FF_BANK_SCHED_STATS_EN defined: 5 completed ops give op_cnt=5; R clears it to 0.
